// File: rtl/rm_lift_stream.sv
// rm_lift_stream
// Captures the sampled r||m trit vector when the sampler reports completion,
// then streams r and m (N coefficients each, last one a zero pad) to the Rq
// multiplier over valid/ready. Trits {0,1,2} are lifted to {0,1,q-1}.
//
// Ports:
//   local_clk   clock, posedge
//   rst         asynchronous active-high reset
//   rm_in       sampled vector, trit k at rm_in[2k+2:2k+1]
//   rm_done     sampler completion level
//   coef        lifted coefficient
//   coef_valid  coef/poly_sel/coef_idx/last valid
//   coef_ready  consumer ready
//   poly_sel    0 = r, 1 = m
//   coef_idx    index within current polynomial
//   last        final coefficient of m
//   busy        streaming in progress
//   done        sticky, stream complete
//   err         sticky, an illegal trit (3) was emitted
//
// state  | meaning
// IDLE   | waiting for rm_done, captures rm_in
// EMIT_R | streaming r, idx 0..N-1 (N-1 is the pad)
// EMIT_M | streaming m, idx 0..N-1 (N-1 is the pad)
// DONE   | terminal until rst
module rm_lift_stream #(
    parameter int RM_BITS = 2800,
    parameter int N       = 701,
    parameter int Q_BITS  = 13
) (
    input  logic               local_clk,
    input  logic               rst,
    input  logic [RM_BITS-1:0] rm_in,
    input  logic               rm_done,
    output logic [Q_BITS-1:0]  coef,
    output logic               coef_valid,
    input  logic               coef_ready,
    output logic               poly_sel,
    output logic [9:0]         coef_idx,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EMIT_R = 2'd1;
    localparam logic [1:0] S_EMIT_M = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [9:0] IDX_LAST = 10'(N - 1);

    logic [1:0]         state_q, state_d;
    logic [RM_BITS-1:0] sr_q, sr_d;
    logic [9:0]         idx_q, idx_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               emitting;
    logic               is_pad;
    logic [1:0]         trit;
    logic [Q_BITS-1:0]  lifted;

    assign emitting = (state_q == S_EMIT_R) || (state_q == S_EMIT_M);
    assign is_pad   = (idx_q == IDX_LAST);
    assign trit     = sr_q[2:1];

    always_comb begin
        case (trit)
            2'd1:    lifted = {{(Q_BITS-1){1'b0}}, 1'b1};
            2'd2:    lifted = {Q_BITS{1'b1}};
            default: lifted = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (rm_done) begin
                    sr_d    = rm_in;
                    idx_d   = '0;
                    state_d = S_EMIT_R;
                end
            end
            S_EMIT_R, S_EMIT_M: begin
                if (coef_ready) begin
                    if (!is_pad) begin
                        sr_d  = sr_q >> 2;
                        idx_d = idx_q + 10'd1;
                        if (trit == 2'd3) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        // Pad transfer does not shift: after r's pad, trit 700 is already at [2:1].
                        idx_d = '0;
                        if (state_q == S_EMIT_R) begin
                            state_d = S_EMIT_M;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign coef_valid = emitting;
    assign coef       = (emitting && !is_pad) ? lifted : '0;
    assign poly_sel   = (state_q == S_EMIT_M);
    assign coef_idx   = idx_q;
    assign last       = (state_q == S_EMIT_M) && is_pad;
    assign busy       = emitting;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rm_lift_stream.sv
module tb_rm_lift_stream;

    localparam int RM_BITS = 2800;
    localparam int N       = 701;
    localparam int Q_BITS  = 13;
    localparam int TOTAL   = 2 * N;

    logic               local_clk;
    logic               rst;
    logic [RM_BITS-1:0] rm_in;
    logic               rm_done;
    logic [Q_BITS-1:0]  coef;
    logic               coef_valid;
    logic               coef_ready;
    logic               poly_sel;
    logic [9:0]         coef_idx;
    logic               last;
    logic               busy;
    logic               done;
    logic               err;

    rm_lift_stream #(.RM_BITS(RM_BITS), .N(N), .Q_BITS(Q_BITS)) dut (
        .local_clk (local_clk),
        .rst       (rst),
        .rm_in     (rm_in),
        .rm_done   (rm_done),
        .coef      (coef),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .poly_sel  (poly_sel),
        .coef_idx  (coef_idx),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial local_clk = 1'b0;
    always #5 local_clk = ~local_clk;

    int checks = 0;
    int errors = 0;

    // Model: the expected transfer sequence, derived from the vector the bench loaded.
    logic [RM_BITS-1:0] rm_cur;
    int                 exp_coef  [TOTAL];
    bit                 err_after [TOTAL+1];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int trit_of(input int k);
        int hi;
        int lo;
        hi = (2*k+2 < RM_BITS) ? int'(rm_cur[2*k+2]) : 0;
        lo = int'(rm_cur[2*k+1]);
        return hi*2 + lo;
    endfunction

    task automatic set_trit(input int k, input int v);
        rm_cur[2*k+1] = v[0];
        if (2*k+2 < RM_BITS) rm_cur[2*k+2] = v[1];
    endtask

    function automatic int lift(input int t);
        case (t)
            1:       return 1;
            2:       return (1 << Q_BITS) - 1;
            default: return 0;
        endcase
    endfunction

    task automatic build_model();
        err_after[0] = 1'b0;
        for (int j = 0; j < TOTAL; j++) begin
            int p;
            int i;
            int t;
            p = j / N;
            i = j % N;
            t = (i == N-1) ? 0 : trit_of(p*(N-1) + i);
            exp_coef[j]    = (i == N-1) ? 0 : lift(t);
            err_after[j+1] = err_after[j] || ((i != N-1) && (t == 3));
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " coef_valid"}, coef_valid, 0);
        chk({tag, " coef"},       coef,       0);
        chk({tag, " poly_sel"},   poly_sel,   0);
        chk({tag, " coef_idx"},   coef_idx,   0);
        chk({tag, " last"},       last,       0);
        chk({tag, " busy"},       busy,       0);
        chk({tag, " done"},       done,       0);
        chk({tag, " err"},        err,        0);
    endtask

    task automatic do_reset();
        rm_done    = 1'b0;
        coef_ready = 1'b0;
        rst        = 1'b1;
        #3;
        check_cleared("reset");
        @(negedge local_clk);
        rst = 1'b0;
    endtask

    // Called at a negedge. Starts a run and compares every cycle against the model.
    // stop_at >= 0 returns (at a negedge) once that many transfers completed.
    task automatic stream(input string tag, input int stop_at, input bit rnd,
                          input bit keep_done, input bit scramble);
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        rm_in      = rm_cur;
        rm_done    = 1'b1;
        coef_ready = 1'b1;
        @(posedge local_clk);
        @(negedge local_clk);
        if (!keep_done) rm_done = 1'b0;
        if (scramble) rm_in = ~rm_cur;
        forever begin
            cyc++;
            if (n == TOTAL) begin
                chk({tag, " done"},       done,       1);
                chk({tag, " busy end"},   busy,       0);
                chk({tag, " valid end"},  coef_valid, 0);
                chk({tag, " err end"},    err,        int'(err_after[TOTAL]));
                if (!rnd) chk({tag, " done latency"}, cyc, TOTAL + 1);
                break;
            end
            if (n == stop_at) break;
            if (cyc > 6000) begin
                chk({tag, " timeout transfers"}, n, TOTAL);
                break;
            end
            chk({tag, " valid"},    coef_valid, 1);
            chk({tag, " busy"},     busy,       1);
            chk({tag, " coef"},     coef,       exp_coef[n]);
            chk({tag, " poly_sel"}, poly_sel,   (n >= N) ? 1 : 0);
            chk({tag, " idx"},      coef_idx,   n % N);
            chk({tag, " last"},     last,       (n == TOTAL-1) ? 1 : 0);
            chk({tag, " done mid"}, done,       0);
            chk({tag, " err"},      err,        int'(err_after[n]));
            coef_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (coef_ready) n++;
            @(negedge local_clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        rm_in      = '0;
        rm_done    = 1'b0;
        coef_ready = 1'b0;
        #2;
        do_reset();

        // All-zero vector, ready tied high.
        rm_cur = '0;
        build_model();
        chk("model zero coef 700", exp_coef[700], 0);
        stream("zeros", -1, 1'b0, 1'b0, 1'b0);

        // trit k = k mod 3; rm_in scrambled after capture must not matter.
        do_reset();
        rm_cur = '0;
        for (int k = 0; k < 1400; k++) set_trit(k, k % 3);
        build_model();
        chk("model r0", exp_coef[0], 0);
        chk("model r1", exp_coef[1], 1);
        chk("model r2", exp_coef[2], 8191);
        chk("model r3", exp_coef[3], 0);
        chk("model r4", exp_coef[4], 1);
        chk("model r5", exp_coef[5], 8191);
        chk("model r pad", exp_coef[700], 0);
        chk("model m0", exp_coef[701], 1);
        stream("mod3", -1, 1'b0, 1'b0, 1'b1);

        // Same data with random back-pressure.
        do_reset();
        stream("mod3 rnd", -1, 1'b1, 1'b0, 1'b0);

        // Illegal trit at index 5.
        do_reset();
        set_trit(5, 3);
        build_model();
        chk("model t3 coef", exp_coef[5], 0);
        chk("model t3 err before", int'(err_after[5]), 0);
        chk("model t3 err after", int'(err_after[6]), 1);
        stream("trit3", -1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of r, then rerun on fresh data.
        do_reset();
        for (int k = 0; k < 1400; k++) set_trit(k, (k * 7 + 2) % 3);
        build_model();
        stream("pre rst", 300, 1'b0, 1'b0, 1'b0);
        chk("pre rst idx", coef_idx, 300);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("mid rst");
        @(negedge local_clk);
        rst = 1'b0;
        @(negedge local_clk);
        check_cleared("idle after rst");
        rm_cur = '0;
        for (int k = 0; k < 1400; k++) set_trit(k, int'($urandom_range(0, 2)));
        rm_cur[0] = 1'b1;
        build_model();
        stream("rerun", -1, 1'b1, 1'b1, 1'b0);

        // rm_done stays high after done: no second run.
        for (int c = 0; c < 2000; c++) begin
            @(negedge local_clk);
            chk("post done valid", coef_valid, 0);
        end
        chk("post done flag", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rm_lift_stream.md
# rm_lift_stream

Downstream consumer of the ternary sampler in the Encaps datapath. When the sampler signals completion, this block captures the 2800-bit trit vector, which holds the polynomials r and m. It then streams both polynomials one coefficient per transfer to the Rq multiplier over a valid/ready handshake. Each trit is lifted from {0,1,2} to its Z_q representative {0, 1, q-1}, and each polynomial is zero-padded to N coefficients.

## Interface
Parameters:
- RM_BITS, 2800, width of sampled vector (2 bits per trit, 1400 trits)
- N, 701, coefficients emitted per polynomial (700 sampled + 1 zero pad)
- Q_BITS, 13, coefficient width; q = 2^Q_BITS

Ports:
- local_clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rm_in  in  RM_BITS  sampled vector; trit k = rm_in[2k+2:2k+1], k = 0..1399
- rm_done  in  1  level from sampler; high = rm_in final and stable
- coef  out  Q_BITS  lifted coefficient
- coef_valid  out  1  coef/poly_sel/coef_idx/last valid
- coef_ready  in  1  consumer accepts on valid & ready at posedge
- poly_sel  out  1  0 = r (trits 0..699), 1 = m (trits 700..1399)
- coef_idx  out  10  index within current polynomial, 0..N-1
- last  out  1  high with coefficient idx N-1 of m
- busy  out  1  high in EMIT_R / EMIT_M
- done  out  1  sticky; high after final transfer until rst
- err  out  1  sticky; a trit of value 3 was emitted

## Operation
- Internal state: FSM {IDLE, EMIT_R, EMIT_M, DONE}, RM_BITS shift register sr, 10-bit counter idx, sticky err and done flags.
- IDLE, rm_done=1 at an edge: sr <= rm_in, idx <= 0, state <= EMIT_R.
- IDLE, rm_done=0: hold.
- EMIT_R / EMIT_M, combinational outputs:
  - coef_valid = 1.
  - t = sr[2:1].
  - coef = lift(t) when idx < N-1; coef = 0 when idx = N-1 (pad).
  - lift: 0→0, 1→1, 2→2^Q_BITS-1, 3→0 (illegal).
- Transfer (valid & ready) with idx < N-1: sr <= sr >> 2, idx <= idx+1. If t == 3: err <= 1.
- Transfer with idx = N-1: no shift, idx <= 0.
  - EMIT_R goes to EMIT_M; sr now holds trit 700 at [2:1].
  - EMIT_M goes to DONE; done <= 1.
- No transfer (ready=0): all state, and therefore all outputs, held stable. Outputs never change while valid & !ready.
- DONE: coef_valid=0, busy=0. Block is terminal until rst; rm_done is ignored, so there is exactly one run per reset even if rm_done stays high.
- poly_sel = (state == EMIT_M). last = (state == EMIT_M) & (idx == N-1).
- Width rules: idx is 10 bits, N-1 = 700 fits. Pad coefficient and lift(0) are all-zero Q_BITS. q-1 is all-ones.

## Timing
- Reset values, all asserted asynchronously: state=IDLE, sr=0, idx=0, coef_valid=0, coef=0, poly_sel=0, coef_idx=0, last=0, busy=0, done=0, err=0.
- Latency: rm_done sampled high at edge t gives coef_valid=1 with trit 0 just after edge t.
- Throughput: one coefficient per cycle with coef_ready tied high. 2N = 1402 transfers. done rises after edge t+1402.
- Seamless r→m switch: first m coefficient is valid in the cycle right after the r pad transfer. No bubble.
- rst mid-stream: immediate return to IDLE with all outputs cleared. A new run starts at the first edge after rst deasserts at which rm_done=1.
- rm_in is sampled only at the IDLE→EMIT_R edge. Later changes to rm_in have no effect.

## Test plan
- rm_in all zeros, rm_done=1, ready=1:
  - 1402 transfers, all coef=0.
  - poly_sel flips after transfer 701; last only on transfer 1402.
  - done after edge t+1402, err=0.
- rm_in with trit k = k mod 3:
  - r idx 0..5 gives 0, 1, 8191, 0, 1, 8191.
  - r idx 700 = 0 (pad).
  - m idx 0 = trit 700 → 1 (700 mod 3 = 1).
- Random ready (~50% duty): coef/idx/poly_sel held stable while ready=0. Sequence identical to the ready=1 run; 1402 accepted transfers total.
- Trit 5 = 3 in rm_in: coef=0 at r idx 5, err rises after that transfer and stays high through done.
- rst pulse at r idx 300:
  - Outputs clear immediately.
  - Rerun with a new rm_in streams from r idx 0 using the new data.
- rm_done held high after done: no further coef_valid for 2000 cycles.
